// File: rtl/ov5640_cfg_ctrl.sv
// ov5640_cfg_ctrl
//   Power-up and register-configuration sequencer for the OV5640 camera.
//   On start it power-cycles the sensor (PWDN high, then reset low, then reset
//   released and an init wait). It then walks an external register table and
//   issues one SCCB write per entry through a req/ack handshake. It raises
//   cap_en only after the whole table has been written, which gates the DVP
//   capture datapath.
//
//   Build option: define OV5640_CFG_VERIFY_EN to read back every register
//   after its write acks. A readback mismatch or a read NACK counts as a
//   failed attempt and restarts that entry with the write.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               1-cycle pulse, (re)start the full sequence (ignored while busy)
//   cam_pwdn, cam_rst_n sensor power-down (1 = down) and hardware reset (active-low)
//   tbl_idx, tbl_entry  table index out; {reg_addr, reg_data} back one cycle later
//   sccb_req/rd/addr/wdata  request to the SCCB master, held until ack/nack
//   sccb_ack/nack/rdata     completion pulses and read data from the SCCB master
//   busy, cfg_done, cfg_err status; cfg_done/cfg_err stay set until next start/rst
//   cap_en              registered cfg_done & ~cfg_err
module ov5640_cfg_ctrl #(
  parameter int unsigned REG_NUM      = 250,
  parameter int unsigned T_PWDN_CYC   = 50000,
  parameter int unsigned T_RST_CYC    = 50000,
  parameter int unsigned T_INIT_CYC   = 1000000,
  parameter int unsigned DLY_UNIT_CYC = 50000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cam_pwdn,
  output logic        cam_rst_n,
  output logic [7:0]  tbl_idx,
  input  logic [23:0] tbl_entry,
  output logic        sccb_req,
  output logic        sccb_rd,
  output logic [15:0] sccb_addr,
  output logic [7:0]  sccb_wdata,
  input  logic        sccb_ack,
  input  logic        sccb_nack,
  input  logic [7:0]  sccb_rdata,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        cap_en
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWDN, S_RST, S_INIT, S_FETCH, S_LATCH,
    S_WRITE, S_READ, S_DELAY, S_NEXT, S_DONE, S_ERR
  } state_t;

  // The timing parameters are assumed to be at least 1 cycle each.
  localparam logic [7:0]  LAST_IDX    = 8'(REG_NUM - 1);
  localparam logic [7:0]  MAX_RETRY_L = 8'(MAX_RETRY);
  localparam logic [31:0] PWDN_LOAD   = 32'(T_PWDN_CYC - 1);
  localparam logic [31:0] RST_LOAD    = 32'(T_RST_CYC - 1);
  localparam logic [31:0] INIT_LOAD   = 32'(T_INIT_CYC - 1);

`ifdef OV5640_CFG_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  tbl_idx_q, tbl_idx_d;
  logic        cam_pwdn_q, cam_pwdn_d;
  logic        cam_rst_n_q, cam_rst_n_d;
  logic        sccb_req_q, sccb_req_d;
  logic        sccb_rd_q, sccb_rd_d;
  logic [15:0] sccb_addr_q, sccb_addr_d;
  logic [7:0]  sccb_wdata_q, sccb_wdata_d;
  logic        busy_q, busy_d;
  logic        cfg_done_q, cfg_done_d;
  logic        cfg_err_q, cfg_err_d;
  logic        cap_en_q, cap_en_d;

  // Completion pulses only count while a request is outstanding; a
  // simultaneous ack and nack is treated as a nack.
  logic xact_ok;
  logic xact_fail;
  logic is_delay_entry;

  assign is_delay_entry = (tbl_entry[23:8] == 16'hFFFF);
  assign xact_ok        = sccb_req_q & sccb_ack & ~sccb_nack;

`ifdef OV5640_CFG_VERIFY_EN
  assign xact_fail = sccb_req_q &
                     (sccb_nack | (sccb_ack & sccb_rd_q & (sccb_rdata != sccb_wdata_q)));
`else
  logic unused_rdata;
  assign unused_rdata = ^sccb_rdata;
  assign xact_fail    = sccb_req_q & sccb_nack;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      tbl_idx_q    <= '0;
      cam_pwdn_q   <= 1'b1;
      cam_rst_n_q  <= 1'b0;
      sccb_req_q   <= 1'b0;
      sccb_rd_q    <= 1'b0;
      sccb_addr_q  <= '0;
      sccb_wdata_q <= '0;
      busy_q       <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      cap_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      tbl_idx_q    <= tbl_idx_d;
      cam_pwdn_q   <= cam_pwdn_d;
      cam_rst_n_q  <= cam_rst_n_d;
      sccb_req_q   <= sccb_req_d;
      sccb_rd_q    <= sccb_rd_d;
      sccb_addr_q  <= sccb_addr_d;
      sccb_wdata_q <= sccb_wdata_d;
      busy_q       <= busy_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      cap_en_q     <= cap_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    tbl_idx_d    = tbl_idx_q;
    cam_pwdn_d   = cam_pwdn_q;
    cam_rst_n_d  = cam_rst_n_q;
    sccb_req_d   = sccb_req_q;
    sccb_rd_d    = sccb_rd_q;
    sccb_addr_d  = sccb_addr_q;
    sccb_wdata_d = sccb_wdata_q;
    busy_d       = busy_q;
    cfg_done_d   = cfg_done_q;
    cfg_err_d    = cfg_err_q;
    cap_en_d     = cfg_done_q & ~cfg_err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          // Every start performs a full power cycle of the sensor.
          state_d     = S_PWDN;
          cnt_d       = PWDN_LOAD;
          cam_pwdn_d  = 1'b1;
          cam_rst_n_d = 1'b0;
          tbl_idx_d   = '0;
          busy_d      = 1'b1;
          cfg_done_d  = 1'b0;
          cfg_err_d   = 1'b0;
          cap_en_d    = 1'b0;
        end
      end

      S_PWDN: begin
        if (cnt_q == 32'd0) begin
          state_d    = S_RST;
          cnt_d      = RST_LOAD;
          cam_pwdn_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_RST: begin
        if (cnt_q == 32'd0) begin
          state_d     = S_INIT;
          cnt_d       = INIT_LOAD;
          cam_rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_INIT: begin
        if (cnt_q == 32'd0) begin
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      // tbl_idx is already stable here; the table answers one cycle later.
      S_FETCH: state_d = S_LATCH;

      S_LATCH: begin
        retry_d = '0;
        if (is_delay_entry) begin
          // DELAY always takes one cycle, plus reg_data*DLY_UNIT_CYC more,
          // so a zero delay costs nothing beyond the normal step.
          state_d = S_DELAY;
          cnt_d   = 32'(tbl_entry[7:0]) * DLY_UNIT_CYC;
        end else begin
          state_d      = S_WRITE;
          sccb_addr_d  = tbl_entry[23:8];
          sccb_wdata_d = tbl_entry[7:0];
          sccb_req_d   = 1'b1;
          sccb_rd_d    = 1'b0;
        end
      end

      S_WRITE, S_READ: begin
        if (!sccb_req_q) begin
          // Idle cycle after a failed attempt or a write->read switch.
          sccb_req_d = 1'b1;
          sccb_rd_d  = (state_q == S_READ);
        end else if (xact_fail) begin
          sccb_req_d = 1'b0;
          sccb_rd_d  = 1'b0;
          if (retry_q == MAX_RETRY_L) begin
            state_d   = S_ERR;
            busy_d    = 1'b0;
            cfg_err_d = 1'b1;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = S_WRITE;
          end
        end else if (xact_ok) begin
          sccb_req_d = 1'b0;
          sccb_rd_d  = 1'b0;
          state_d    = (VERIFY && state_q == S_WRITE) ? S_READ : S_NEXT;
        end
      end

      S_DELAY: begin
        if (cnt_q == 32'd0) begin
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_NEXT: begin
        if (tbl_idx_q == LAST_IDX) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          cfg_done_d = 1'b1;
        end else begin
          tbl_idx_d = tbl_idx_q + 8'd1;
          state_d   = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cam_pwdn   = cam_pwdn_q;
  assign cam_rst_n  = cam_rst_n_q;
  assign tbl_idx    = tbl_idx_q;
  assign sccb_req   = sccb_req_q;
  assign sccb_rd    = sccb_rd_q;
  assign sccb_addr  = sccb_addr_q;
  assign sccb_wdata = sccb_wdata_q;
  assign busy       = busy_q;
  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign cap_en     = cap_en_q;

endmodule

// File: tb/tb_ov5640_cfg_ctrl.sv
// Testbench for ov5640_cfg_ctrl. A small table ROM and an SCCB slave model
// drive the design. Each test pushes its expected SCCB transactions into a
// queue. The slave process pops one entry and compares it at every new
// request. If OV5640_CFG_VERIFY_EN is defined, write acks are followed by
// readbacks and a verify-failure test is added.
module tb_ov5640_cfg_ctrl;

  localparam int REG_NUM = 4;
  localparam int T_PWDN  = 20;
  localparam int T_RST   = 15;
  localparam int T_INIT  = 30;
  localparam int DLY     = 10;
  localparam int RETRY   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cam_pwdn, cam_rst_n;
  logic [7:0]  tbl_idx;
  logic [23:0] tbl_entry = '0;
  logic        sccb_req, sccb_rd;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_wdata;
  logic        sccb_ack = 1'b0, sccb_nack = 1'b0;
  logic [7:0]  sccb_rdata = '0;
  logic        busy, cfg_done, cfg_err, cap_en;

  ov5640_cfg_ctrl #(
    .REG_NUM(REG_NUM), .T_PWDN_CYC(T_PWDN), .T_RST_CYC(T_RST),
    .T_INIT_CYC(T_INIT), .DLY_UNIT_CYC(DLY), .MAX_RETRY(RETRY)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .sccb_req(sccb_req), .sccb_rd(sccb_rd), .sccb_addr(sccb_addr), .sccb_wdata(sccb_wdata),
    .sccb_ack(sccb_ack), .sccb_nack(sccb_nack), .sccb_rdata(sccb_rdata),
    .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .cap_en(cap_en)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM: entry valid one cycle after tbl_idx.
  logic [23:0] tbl [0:REG_NUM-1];
  always @(posedge clk) tbl_entry <= tbl[tbl_idx[1:0]];

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } xact_t;

  xact_t exp_q[$];
  int    chk_cnt  = 0;
  int    pass_cnt = 0;
  int    n_req    = 0;

  // Slave behaviour knobs set by the tests.
  logic [15:0] nack_addr   = 16'h0000;
  int          nack_left   = 0;
  int          corrupt_left = 0;
  logic [7:0]  last_wdata  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // SCCB slave and scoreboard monitor: answer 5 cycles into each request.
  initial begin : slave
    logic        req_prev;
    logic        is_rd;
    logic [15:0] a;
    logic [7:0]  d;
    xact_t       x;
    bit          do_nack;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (sccb_req && !req_prev) begin
        n_req++;
        is_rd = sccb_rd;
        a     = sccb_addr;
        d     = sccb_wdata;
        $display("xact %0d: %s addr=%04h wdata=%02h", n_req, is_rd ? "RD" : "WR", a, d);
        if (exp_q.size() == 0) begin
          check("xact_unexpected_count", 32'(exp_q.size() + 1), 32'd0);
        end else begin
          x = exp_q.pop_front();
          check("xact_rd", 32'(is_rd), 32'(x.rd));
          check("xact_addr", 32'(a), 32'(x.addr));
          if (!x.rd) check("xact_wdata", 32'(d), 32'(x.data));
        end
        repeat (4) @(negedge clk);
        do_nack = 1'b0;
        if (is_rd) begin
          if (corrupt_left > 0) begin
            sccb_rdata = 8'h00;
            corrupt_left--;
          end else begin
            sccb_rdata = last_wdata;
          end
        end else if (a == nack_addr && nack_left > 0) begin
          do_nack = 1'b1;
          nack_left--;
        end else begin
          last_wdata = d;
        end
        if (do_nack) sccb_nack = 1'b1;
        else         sccb_ack  = 1'b1;
        @(negedge clk);
        sccb_ack  = 1'b0;
        sccb_nack = 1'b0;
      end
      req_prev = sccb_req;
    end
  end

  // Expected successful write (plus its readback when verifying).
  task automatic push_w(input logic [23:0] e);
    exp_q.push_back({1'b0, e});
`ifdef OV5640_CFG_VERIFY_EN
    exp_q.push_back({1'b1, e});
`endif
  endtask

  // Expected write attempt that will be nacked (no readback follows).
  task automatic push_w_fail(input logic [23:0] e);
    exp_q.push_back({1'b0, e});
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 32'(cfg_done | cfg_err), 32'd1);
  endtask

  task automatic check_reset_vals();
    check("rst_cam_pwdn", 32'(cam_pwdn), 32'd1);
    check("rst_cam_rst_n", 32'(cam_rst_n), 32'd0);
    check("rst_tbl_idx", 32'(tbl_idx), 32'd0);
    check("rst_sccb_req", 32'(sccb_req), 32'd0);
    check("rst_sccb_rd", 32'(sccb_rd), 32'd0);
    check("rst_sccb_addr", 32'(sccb_addr), 32'd0);
    check("rst_sccb_wdata", 32'(sccb_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cfg_done", 32'(cfg_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_cap_en", 32'(cap_en), 32'd0);
  endtask

  task automatic load_default_table();
    tbl[0] = {16'h3008, 8'h42};
    tbl[1] = {16'h3103, 8'h03};
    tbl[2] = {16'h3017, 8'hFF};
    tbl[3] = {16'h3018, 8'hF3};
  endtask

  task automatic push_default_table();
    for (int i = 0; i < REG_NUM; i++) push_w(tbl[i]);
  endtask

  // Count consecutive low cycles of sccb_req after the current request ends.
  task automatic measure_req_gap(output int gap);
    int n = 0;
    while (!sccb_req && n < 2000) begin @(negedge clk); n++; end
    n = 0;
    while (sccb_req && n < 2000) begin @(negedge clk); n++; end
    gap = 0;
    while (!sccb_req && gap < 2000) begin @(negedge clk); gap++; end
  endtask

  initial begin : stim
    int n;
    int base;
    int pushed;

    // ---------------- Test 1: reset state, pin timing, 4 writes ----------------
    load_default_table();
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    push_default_table();
    base = n_req; pushed = exp_q.size();
    pulse_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (cam_pwdn && n < 1000) begin n++; @(negedge clk); end
    check("t1_pwdn_cycles", 32'(n), 32'(T_PWDN));
    n = 0;
    while (!cam_pwdn && !cam_rst_n && n < 1000) begin n++; @(negedge clk); end
    check("t1_rst_cycles", 32'(n), 32'(T_RST));
    n = 0;
    while (cam_rst_n && !sccb_req && n < 1000) begin n++; @(negedge clk); end
    check("t1_init_to_req", 32'(n), 32'(T_INIT + 2));
    wait_end(5000);
    check("t1_cfg_done", 32'(cfg_done), 32'd1);
    check("t1_cfg_err", 32'(cfg_err), 32'd0);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_cap_en_lag", 32'(cap_en), 32'd0);
    @(negedge clk);
    check("t1_cap_en", 32'(cap_en), 32'd1);
    check("t1_xact_count", 32'(n_req - base), 32'(pushed));

    // ---------------- Test 2: delay entry of 3 units ----------------
    tbl[1] = {16'hFFFF, 8'd3};
    push_w(tbl[0]); push_w(tbl[2]); push_w(tbl[3]);
    base = n_req; pushed = exp_q.size();
    pulse_start();
`ifdef OV5640_CFG_VERIFY_EN
    measure_req_gap(n);   // write->read gap of entry 0
`endif
    measure_req_gap(n);
    // NEXT, FETCH, LATCH around the delay entry twice plus 31 DELAY cycles.
    check("t2_delay_gap", 32'(n), 32'(3 * DLY + 7));
    wait_end(5000);
    check("t2_cfg_done", 32'(cfg_done), 32'd1);
    check("t2_xact_count", 32'(n_req - base), 32'(pushed));

    // ---------------- Test 3: two nacks then ack on entry 1 ----------------
    load_default_table();
    nack_addr = tbl[1][23:8]; nack_left = 2;
    push_w(tbl[0]);
    push_w_fail(tbl[1]); push_w_fail(tbl[1]); push_w(tbl[1]);
    push_w(tbl[2]); push_w(tbl[3]);
    base = n_req; pushed = exp_q.size();
    pulse_start();
    wait_end(5000);
    check("t3_cfg_done", 32'(cfg_done), 32'd1);
    check("t3_cfg_err", 32'(cfg_err), 32'd0);
    check("t3_xact_count", 32'(n_req - base), 32'(pushed));

    // ---------------- Test 4: retries exhausted on entry 2 ----------------
    nack_addr = tbl[2][23:8]; nack_left = RETRY + 1;
    push_w(tbl[0]); push_w(tbl[1]);
    for (int i = 0; i <= RETRY; i++) push_w_fail(tbl[2]);
    base = n_req; pushed = exp_q.size();
    pulse_start();
    wait_end(5000);
    check("t4_cfg_err", 32'(cfg_err), 32'd1);
    check("t4_cfg_done", 32'(cfg_done), 32'd0);
    check("t4_busy_low", 32'(busy), 32'd0);
    check("t4_cam_rst_n_kept", 32'(cam_rst_n), 32'd1);
    repeat (50) @(negedge clk);
    check("t4_cap_en", 32'(cap_en), 32'd0);
    check("t4_xact_count", 32'(n_req - base), 32'(pushed));
    nack_left = 0;

    // ---------------- Test 5: reset during WRITE, then rerun ----------------
    exp_q.push_back({1'b0, tbl[0]});
    pulse_start();
    n = 0;
    while (!sccb_req && n < 1000) begin @(negedge clk); n++; end
    check("t5_req_seen", 32'(sccb_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals();
    repeat (8) @(negedge clk);
    rst = 1'b0;
    check("t5_queue_drained", 32'(exp_q.size()), 32'd0);
    push_default_table();
    base = n_req; pushed = exp_q.size();
    pulse_start();
    n = 0;
    while (cam_pwdn && n < 1000) begin n++; @(negedge clk); end
    check("t5_pwdn_cycles", 32'(n), 32'(T_PWDN));
    wait_end(5000);
    check("t5_cfg_done", 32'(cfg_done), 32'd1);
    check("t5_xact_count", 32'(n_req - base), 32'(pushed));

`ifdef OV5640_CFG_VERIFY_EN
    // ---------------- Test 6: readback mismatch, then match ----------------
    corrupt_left = 1;
    exp_q.push_back({1'b0, tbl[0]});
    exp_q.push_back({1'b1, tbl[0]});
    push_default_table();
    base = n_req; pushed = exp_q.size();
    pulse_start();
    wait_end(5000);
    check("t6_cfg_done", 32'(cfg_done), 32'd1);
    check("t6_cfg_err", 32'(cfg_err), 32'd0);
    check("t6_xact_count", 32'(n_req - base), 32'(pushed));
`endif

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
